// File: rtl/pixel_sensor_pkg.sv
// Shared types for the pixel array sensor.
//   cmd_e     : command encoding on the cmd port (ERASE/EXPOSE/CONVERT/READ)
//   state_e   : controller FSM states
//   bin2gray  : binary-to-Gray conversion used by the optional Gray readout
//               (build with PIX_GRAY_OUT_EN defined to enable it)
package pixel_sensor_pkg;

  typedef enum logic [1:0] {
    CMD_ERASE   = 2'd0,
    CMD_EXPOSE  = 2'd1,
    CMD_CONVERT = 2'd2,
    CMD_READ    = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_READOUT
  } state_e;

  // Operates on a 32-bit container; callers keep the low ADC_BITS.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/pixel_cell.sv
// One pixel: integration node v, comparator flag cmp and ADC latch lat.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   erase             restore node to full scale, clear cmp and lat
//   expose            one integration step: v -= light, floored at 0
//   conv_clr          clear comparator at the start of a conversion
//   convert           one ramp step: track ramp into lat until ramp > v
//   light [ADC_BITS]  per-cycle discharge amount
//   ramp  [ADC_BITS]  shared ramp value
//   code  [ADC_BITS]  latched conversion result
module pixel_cell #(
  parameter int ADC_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                erase,
  input  logic                expose,
  input  logic                conv_clr,
  input  logic                convert,
  input  logic [ADC_BITS-1:0] light,
  input  logic [ADC_BITS-1:0] ramp,
  output logic [ADC_BITS-1:0] code
);

  logic [ADC_BITS-1:0] v;
  logic                cmp;
  logic [ADC_BITS-1:0] lat;

  // Saturating subtract: a difference that goes negative floors at zero.
  function automatic logic [ADC_BITS-1:0] sat_sub(input logic [ADC_BITS-1:0] a,
                                                  input logic [ADC_BITS-1:0] b);
    logic signed [ADC_BITS:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    return diff[ADC_BITS] ? '0 : diff[ADC_BITS-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v   <= '1;
      cmp <= 1'b0;
      lat <= '0;
    end else if (erase) begin
      v   <= '1;
      cmp <= 1'b0;
      lat <= '0;
    end else begin
      if (expose)
        v <= sat_sub(v, light);
      if (conv_clr)
        cmp <= 1'b0;
      else if (convert && !cmp) begin
        // lat follows the ramp until the ramp first exceeds the node, so
        // the value left behind equals v.
        if (ramp > v)
          cmp <= 1'b1;
        else
          lat <= ramp;
      end
    end
  end

  assign code = lat;

endmodule

// File: rtl/pixel_array_sensor.sv
// Multi-pixel digital sensor model: command FSM, exposure counter, shared
// ramp counter for single-slope conversion, and valid/ready readout of the
// latched codes one pixel per beat.
// Optional feature: define PIX_GRAY_OUT_EN to emit Gray-coded out_data.
// Ports:
//   clk, reset_n           clock, async active-low reset
//   cmd_valid, cmd, cmd_ready  command handshake (accepted only in IDLE)
//   exp_len                exposure length, sampled on EXPOSE acceptance
//   light                  per-pixel discharge, pixel k at [k*ADC_BITS +: ADC_BITS]
//   out_valid/out_ready    readout handshake
//   out_data, out_idx, out_last  readout word, its pixel index, last flag
//   busy                   high whenever not IDLE
//   done                   one-cycle pulse in the first IDLE cycle after an op
module pixel_array_sensor
  import pixel_sensor_pkg::*;
#(
  parameter int N_PIX    = 4,
  parameter int ADC_BITS = 8,
  parameter int EXP_W    = 16,
  localparam int IDX_W   = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  input  logic [1:0]                cmd,
  output logic                      cmd_ready,
  input  logic [EXP_W-1:0]          exp_len,
  input  logic [N_PIX*ADC_BITS-1:0] light,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADC_BITS-1:0]       out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam logic [ADC_BITS-1:0] FULL     = '1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_PIX - 1);

  state_e              state, state_nx;
  cmd_e                cmd_in;
  logic [EXP_W-1:0]    exp_cnt;
  logic [ADC_BITS-1:0] ramp;
  logic                accept;
  logic                erase_s, expose_s, conv_clr_s, conv_s;
  logic                beat;
  logic [ADC_BITS-1:0] code [N_PIX];
  logic [ADC_BITS-1:0] lat_sel;
  logic [31:0]         gray_w;

  assign cmd_in = cmd_e'(cmd);
  assign beat   = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_in)
            CMD_ERASE:   state_nx = ST_ERASE;
            CMD_EXPOSE:  state_nx = ST_EXPOSE;
            CMD_CONVERT: state_nx = ST_CONVERT;
            CMD_READ:    state_nx = ST_READOUT;
            default:     state_nx = ST_IDLE;
          endcase
        end
      end
      ST_ERASE:   state_nx = ST_IDLE;
      // exp_cnt of 0 or 1 both leave after this cycle.
      ST_EXPOSE:  if (exp_cnt <= EXP_W'(1)) state_nx = ST_IDLE;
      ST_CONVERT: if (ramp == FULL) state_nx = ST_IDLE;
      ST_READOUT: if (beat && out_idx == LAST_IDX) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    cmd_ready  = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    accept     = cmd_valid && (state == ST_IDLE);
    erase_s    = (state == ST_ERASE);
    expose_s   = (state == ST_EXPOSE) && (exp_cnt != '0);
    conv_clr_s = accept && (cmd_in == CMD_CONVERT);
    conv_s     = (state == ST_CONVERT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_cnt   <= '0;
      ramp      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state != ST_IDLE) && (state_nx == ST_IDLE);

      if (accept && cmd_in == CMD_EXPOSE) exp_cnt <= exp_len;
      else if (expose_s)                  exp_cnt <= exp_cnt - EXP_W'(1);

      if (conv_clr_s)  ramp <= '0;
      else if (conv_s) ramp <= ramp + ADC_BITS'(1);

      if (accept && cmd_in == CMD_READ) begin
        out_valid <= 1'b1;
        out_idx   <= '0;
      end else if (beat) begin
        if (out_idx == LAST_IDX) begin
          out_valid <= 1'b0;
          out_idx   <= '0;
        end else begin
          out_idx <= out_idx + IDX_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < N_PIX; k++) begin : g_pix
    pixel_cell #(.ADC_BITS(ADC_BITS)) u_cell (
      .clk      (clk),
      .reset_n  (reset_n),
      .erase    (erase_s),
      .expose   (expose_s),
      .conv_clr (conv_clr_s),
      .convert  (conv_s),
      .light    (light[k*ADC_BITS +: ADC_BITS]),
      .ramp     (ramp),
      .code     (code[k])
    );
  end

  always_comb begin
    lat_sel = '0;
    for (int k = 0; k < N_PIX; k++)
      if (out_idx == IDX_W'(k)) lat_sel = code[k];
  end

  assign gray_w = bin2gray(32'(lat_sel));

`ifdef PIX_GRAY_OUT_EN
  assign out_data = out_valid ? gray_w[ADC_BITS-1:0] : '0;
`else
  assign out_data = out_valid ? lat_sel : '0;
`endif

  assign out_last = out_valid && (out_idx == LAST_IDX);

endmodule

// File: tb/tb_pixel_array_sensor.sv
module tb_pixel_array_sensor;
  import pixel_sensor_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        cmd_ready;
  logic [15:0] exp_len;
  logic [31:0] light;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  pixel_array_sensor #(.N_PIX(4), .ADC_BITS(8), .EXP_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .exp_len   (exp_len),
    .light     (light),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] elen;
    logic [31:0] light;   // {p3,p2,p1,p0}
    logic [31:0] codes;   // expected binary codes {p3,p2,p1,p0}
  } vec_t;

  vec_t vecs[5];

  function automatic logic [7:0] exp_out(input logic [7:0] c);
`ifdef PIX_GRAY_OUT_EN
    return c ^ (c >> 1);
`else
    return c;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input cmd_e c, input logic [15:0] e, input int exp_cycles, input string tag);
    int cyc;
    cyc = 0;
    check({tag, "_ready"}, 32'(cmd_ready), 1);
    cmd = c; exp_len = e; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    while (busy && cyc < 2000) begin
      cyc++;
      tick();
    end
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_ready_back"}, 32'(cmd_ready), 1);
    tick();
    check({tag, "_done_clr"}, 32'(done), 0);
  endtask

  task automatic do_read(input logic [7:0] pat, input int plen, input logic [31:0] codes,
                         input string tag);
    int got, cyc;
    logic [7:0] pd;
    logic [1:0] pi;
    bit pstall;
    got = 0; cyc = 0; pstall = 0; pd = '0; pi = '0;
    cmd = CMD_READ; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check({tag, "_valid_rise"}, 32'(out_valid), 1);
    while (busy && cyc < 1000) begin
      out_ready = pat[cyc % plen];
      if (pstall) begin
        check({tag, "_stall_data"}, 32'(out_data), 32'(pd));
        check({tag, "_stall_idx"}, 32'(out_idx), 32'(pi));
      end
      if (out_valid && out_ready) begin
        check({tag, "_data"}, 32'(out_data), 32'(exp_out(codes[got*8 +: 8])));
        check({tag, "_idx"}, 32'(out_idx), 32'(got));
        check({tag, "_last"}, 32'(out_last), 32'(got == 3));
        got++;
      end
      pstall = out_valid && !out_ready;
      pd = out_data;
      pi = out_idx;
      cyc++;
      tick();
    end
    out_ready = 1'b1;
    check({tag, "_count"}, 32'(got), 4);
    check({tag, "_valid_drop"}, 32'(out_valid), 0);
    check({tag, "_done"}, 32'(done), 1);
    tick();
  endtask

  initial begin
    int cyc;
    vecs[0] = '{16'd10,  {8'd0, 8'd3, 8'd2, 8'd1},     {8'd255, 8'd225, 8'd235, 8'd245}};
    vecs[1] = '{16'd5,   {8'd0, 8'd0, 8'd0, 8'd200},   {8'd255, 8'd255, 8'd255, 8'd0}};
    vecs[2] = '{16'd0,   {8'd7, 8'd7, 8'd7, 8'd7},     {8'd255, 8'd255, 8'd255, 8'd255}};
    vecs[3] = '{16'd3,   {8'd10, 8'd20, 8'd30, 8'd40}, {8'd225, 8'd195, 8'd165, 8'd135}};
    vecs[4] = '{16'd255, {8'd0, 8'd0, 8'd1, 8'd1},     {8'd255, 8'd255, 8'd0, 8'd0}};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd = CMD_ERASE; exp_len = '0;
    light = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_idx", 32'(out_idx), 0);
    check("rst_last", 32'(out_last), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Erase then read: all-zero latches.
    run_op(CMD_ERASE, 16'd0, 1, "erase0");
    do_read(8'hFF, 1, 32'h0, "rd_zero");

    for (int i = 0; i < 5; i++) begin
      light = vecs[i].light;
      run_op(CMD_ERASE, 16'd0, 1, "v_erase");
      run_op(CMD_EXPOSE, vecs[i].elen, (vecs[i].elen == 0) ? 1 : int'(vecs[i].elen), "v_expose");
      run_op(CMD_CONVERT, 16'd0, 256, "v_convert");
      do_read(8'hFF, 1, vecs[i].codes, "v_read");
    end

    // EXPOSE offered during CONVERT must be ignored.
    light = {4{8'd50}};
    cmd = CMD_CONVERT; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      if (cyc >= 10 && cyc < 13) begin
        cmd = CMD_EXPOSE; exp_len = 16'd100; cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
    end
    cmd_valid = 1'b0;
    check("ign_cycles", 32'(cyc), 256);
    check("ign_done", 32'(done), 1);
    tick();
    do_read(8'hFF, 1, vecs[4].codes, "ign_read");

    // Stalled readout, ready pattern 1,0,0,1 repeating.
    do_read(8'b0000_1001, 4, vecs[4].codes, "stall_read");

    // Reset in the middle of a conversion.
    cmd = CMD_CONVERT; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (50) tick();
    check("mid_busy_pre", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_ready", 32'(cmd_ready), 1);
    check("mid_done", 32'(done), 0);
    check("mid_valid", 32'(out_valid), 0);
    check("mid_data", 32'(out_data), 0);
    check("mid_idx", 32'(out_idx), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("mid_done_after", 32'(done), 0);
    check("mid_busy_after", 32'(busy), 0);
    do_read(8'hFF, 1, 32'h0, "post_rst_read");
    run_op(CMD_CONVERT, 16'd0, 256, "post_rst_conv");
    do_read(8'hFF, 1, 32'hFFFF_FFFF, "post_rst_full");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_array_sensor.md
# pixel_array_sensor

Clocked, parametrised model of a digital pixel sensor array: N_PIX pixels, each integrating a per-pixel light level and running a single-slope ramp ADC against a shared ramp counter. The latched codes are streamed out one pixel per beat over a valid/ready port. The block sits between the sensor state-machine controller (command side) and the frame buffer (data side). It replaces the unclocked single-pixel behavioural sensor with a synthesizable, multi-pixel, handshaked model.

## Interface
- N_PIX, 4, number of pixels (≥1)
- ADC_BITS, 8, ADC/ramp resolution; FULL = 2^ADC_BITS−1
- EXP_W, 16, width of the exposure-length input
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command strobe
- cmd  in  2  command: 0 ERASE, 1 EXPOSE, 2 CONVERT, 3 READ
- cmd_ready  out  1  high only in IDLE
- exp_len  in  EXP_W  exposure length in cycles, sampled on EXPOSE acceptance
- light  in  N_PIX*ADC_BITS  per-pixel decrement per exposure cycle, pixel k at [k*ADC_BITS +: ADC_BITS]
- out_valid  out  1  readout word valid
- out_ready  in  1  downstream accept
- out_data  out  ADC_BITS  pixel code
- out_idx  out  $clog2(N_PIX) (min 1)  pixel index of out_data
- out_last  out  1  high with the word of pixel N_PIX−1
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse on return to IDLE

## Operation
- Per pixel: node v[k] (ADC_BITS), comparator flag cmp[k], latch lat[k] (ADC_BITS).
- FSM states IDLE, ERASE, EXPOSE, CONVERT, READOUT. A command is accepted on cmd_valid && cmd_ready; commands presented while busy are ignored, not queued.
- ERASE: v[k]←FULL, cmp[k]←0, lat[k]←0 for all k; one cycle, then IDLE.
- EXPOSE: load exposure counter with exp_len; each EXPOSE cycle v[k]←max(v[k]−light[k],0) (saturating at 0) and counter decrements; exit to IDLE when counter reaches 0. exp_len=0: no decrement, one cycle in EXPOSE.
- CONVERT: clear cmp[k]; ramp r runs 0..FULL, one step per cycle. For each pixel with cmp[k]=0: if r>v[k] then cmp[k]←1 (lat held), else lat[k]←r. Result lat[k]=v[k]. After r=FULL, IDLE.
- READOUT: present lat[idx] for idx 0..N_PIX−1; advance only on out_valid && out_ready; out_data/out_idx stable while stalled. After last beat accepted, IDLE.
- CONVERT/READ without prior ERASE use current state; no error.

## Timing
- Reset: state IDLE, v[k]=FULL, cmp=0, lat=0, ramp=0, cmd_ready=1, busy=0, done=0, out_valid=0, out_data=0, out_idx=0, out_last=0.
- Accepted command at edge n: busy=1 from n+1.
- ERASE: 1 cycle busy. EXPOSE: max(exp_len,1) cycles. CONVERT: 2^ADC_BITS cycles. READOUT: ≥N_PIX cycles, +1 per stalled cycle.
- done pulses in the first IDLE cycle after each operation; cmd_ready reasserts that same cycle.
- out_valid rises the cycle after READ acceptance; drops the cycle after the final handshake.
- Reset asserted mid-operation: immediate return to reset values, no done pulse.

## Configuration
- PIX_GRAY_OUT_EN defined: out_data = lat ^ (lat>>1) (Gray code). lat remains binary internally.
- Not defined: out_data = lat (binary).

## Structure
- Package pixel_sensor_pkg: cmd_e enum (ERASE/EXPOSE/CONVERT/READ), state_e enum, bin2gray function.
- Sub-module pixel_cell (one per pixel, generate loop): holds v, cmp, lat; inputs erase/expose/convert strobes, light, ramp. Top holds FSM, exposure counter, ramp counter, readout mux.

## Test plan
- Reset, ERASE, READ with out_ready=1 -> four words 0,0,0,0, out_last on idx 3, done one cycle later.
- ERASE; EXPOSE exp_len=10, light={0,3,2,1} (pixel3..0); CONVERT; READ -> 245,235,225,255 for idx 0..3; CONVERT busy exactly 256 cycles.
- ERASE; EXPOSE exp_len=5, light pixel0=200 -> v saturates at 0; readout code 0.
- Readout with out_ready toggling 1,0,0,1,… -> out_data/out_idx held during stalls, every pixel delivered exactly once, in order.
- cmd_valid with EXPOSE during CONVERT -> ignored, v unchanged, CONVERT completes normally. reset_n low mid-CONVERT -> all outputs at reset values, no done.
- PIX_GRAY_OUT_EN: code 245 -> out_data 143. Without macro: 245.
